// File: rtl/ycr_clk_gate_n.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// ycr_clk_gate_n : IRQ wake-up clock gate with settle hold, wake source and sleep timer
// Rev 1.0
//------------------------------------------------------------------------------
module ycr_clk_gate_n #(
  parameter int NIRQ  = 4,
  parameter int DLY_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [1:0]       cfg_mode,
  input  logic [NIRQ-1:0]  cfg_irq_mask,
  input  logic [DLY_W-1:0] cfg_wake_dly,
  input  logic             dst_idle,
  input  logic [NIRQ-1:0]  irq,
  output logic             wakeup,
  output logic [NIRQ-1:0]  wake_src,
  output logic [CNT_W-1:0] sleep_cycles,
  output logic             clk_enb,
  output logic             clk_out
);

  localparam int SW = 1 + 2 + NIRQ + DLY_W;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SLEEP     = 2'b01,
    WAKE_HOLD = 2'b10
  } state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    sync_a, sync_b;
  logic             idle_ss, idle_r, idle_pe, irq_hit;
  logic [1:0]       mode_ss;
  logic [NIRQ-1:0]  mask_ss;
  logic [DLY_W-1:0] dly_ss;
  logic [DLY_W-1:0] cnt, cnt_nx;
  logic             wakeup_nx;
  logic [NIRQ-1:0]  wake_src_nx;
  logic [CNT_W-1:0] sleep_nx;
  logic             gate_en;

  // Two-flop synchroniser for every asynchronous control bit
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {dst_idle, cfg_mode, cfg_irq_mask, cfg_wake_dly};
      sync_b <= sync_a;
    end
  end

  assign {idle_ss, mode_ss, mask_ss, dly_ss} = sync_b;
  assign idle_pe = idle_ss & ~idle_r;
  assign irq_hit = |(irq & mask_ss);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idle_r       <= 1'b0;
      cnt          <= '0;
      wakeup       <= 1'b0;
      wake_src     <= '0;
      sleep_cycles <= '0;
    end else begin
      state        <= state_nx;
      idle_r       <= idle_ss;
      cnt          <= cnt_nx;
      wakeup       <= wakeup_nx;
      wake_src     <= wake_src_nx;
      sleep_cycles <= sleep_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    wakeup_nx   = 1'b0;
    wake_src_nx = wake_src;
    sleep_nx    = sleep_cycles;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (mode_ss == 2'b01 && idle_pe && |mask_ss) begin
          state_nx = SLEEP;
          sleep_nx = '0;
        end
      end
      SLEEP: begin
        if (sleep_cycles != {CNT_W{1'b1}})
          sleep_nx = sleep_cycles + 1'b1;
        // Leaving the wake mode abandons the sleep without a wake event
        if (mode_ss != 2'b01) begin
          state_nx = IDLE;
        end else if (irq_hit) begin
          state_nx    = WAKE_HOLD;
          wakeup_nx   = 1'b1;
          wake_src_nx = irq & mask_ss;
          cnt_nx      = '0;
        end
      end
      WAKE_HOLD: begin
        if (mode_ss != 2'b01 || cnt == dly_ss)
          state_nx = IDLE;
        else
          cnt_nx = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (mode_ss)
      2'b10:   clk_enb = 1'b0;
      2'b01:   clk_enb = (state == IDLE);
      default: clk_enb = 1'b1;
    endcase
  end

  // Enable captured while the clock is low, so clk_out never glitches
  always_ff @(negedge clk_in or negedge reset_n) begin
    if (!reset_n) gate_en <= 1'b1;
    else          gate_en <= clk_enb;
  end

  assign clk_out = clk_in & gate_en;

endmodule
`default_nettype wire
